// File: rtl/sar_pkg.sv
// Shared types and constants for the sar_search binary-search controller.
// The optional flag check is enabled with `define SAR_SEARCH_CHECK_EN.
package sar_pkg;

  typedef enum logic {
    SAR_IDLE,
    SAR_PROBE
  } sar_state_t;

  // Bit positions inside the packed {gt,lt,eq} comparator flag vector
  localparam int FLAG_GT = 2;
  localparam int FLAG_LT = 1;
  localparam int FLAG_EQ = 0;
  localparam int FLAG_W  = 3;

endpackage

// File: rtl/sar_search_if.sv
// Control and comparator-side signals of sar_search, bundled for port connection.
// master = environment (starts searches, returns comparator flags), slave = sar_search.
interface sar_search_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] guess;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             cmp_eq;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start, cmp_gt, cmp_lt, cmp_eq,
    input  guess, busy, done, found, result, err
  );

  modport slave (
    input  start, cmp_gt, cmp_lt, cmp_eq,
    output guess, busy, done, found, result, err
  );
endinterface

// File: rtl/sar_bounds.sv
// Combinational bound update for one binary-search probe.
// With SAR_SEARCH_CHECK_EN defined, a non-one-hot flag vector requests an abort.
module sar_bounds
  import sar_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [WIDTH-1:0]  guess,
  input  logic [FLAG_W-1:0] flags,
  output logic [WIDTH-1:0]  lo_next,
  output logic [WIDTH-1:0]  hi_next,
  output logic [WIDTH-1:0]  guess_next,
  output logic              terminate,
  output logic              hit,
  output logic              abort
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Sum kept one bit wider so the midpoint never loses the carry
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return WIDTH'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

  logic [WIDTH-1:0] guess_dec;
  logic [WIDTH-1:0] guess_inc;

  assign guess_dec = guess - ONE;
  assign guess_inc = guess + ONE;

`ifdef SAR_SEARCH_CHECK_EN
  logic flags_onehot;
  assign flags_onehot = $onehot(flags);
`endif

  always_comb begin
    lo_next    = lo;
    hi_next    = hi;
    guess_next = guess;
    terminate  = 1'b0;
    hit        = 1'b0;
    abort      = 1'b0;
`ifdef SAR_SEARCH_CHECK_EN
    if (!flags_onehot) begin
      abort     = 1'b1;
      terminate = 1'b1;
    end else
`endif
    if (flags[FLAG_EQ]) begin
      terminate = 1'b1;
      hit       = 1'b1;
    end else if (flags[FLAG_GT]) begin
      // Bound test precedes the decrement so hi cannot wrap below zero
      if (guess == lo) begin
        terminate = 1'b1;
      end else begin
        hi_next    = guess_dec;
        guess_next = midpoint(lo, guess_dec);
      end
    end else begin
      // lt, or no flag at all when the check is disabled
      if (guess == hi) begin
        terminate = 1'b1;
      end else begin
        lo_next    = guess_inc;
        guess_next = midpoint(guess_inc, hi);
      end
    end
  end

endmodule

// File: rtl/sar_search.sv
// Binary-search controller driving comparator operand A; FSM and registered outputs.
// Optional non-one-hot flag abort: `define SAR_SEARCH_CHECK_EN.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  sar_search_if.slave  bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] FIRST_GUESS = ALL_ONES >> 1;

  sar_state_t       state_reg;
  logic [WIDTH-1:0] guess_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] hi_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             found_reg;
  logic [WIDTH-1:0] result_reg;
  logic             err_reg;

  logic [FLAG_W-1:0] flags;
  logic [WIDTH-1:0]  lo_next;
  logic [WIDTH-1:0]  hi_next;
  logic [WIDTH-1:0]  guess_next;
  logic              terminate;
  logic              hit;
  logic              abort;

  always_comb begin
    flags          = '0;
    flags[FLAG_GT] = bus.cmp_gt;
    flags[FLAG_LT] = bus.cmp_lt;
    flags[FLAG_EQ] = bus.cmp_eq;
  end

  sar_bounds #(
    .WIDTH(WIDTH)
  ) u_bounds (
    .lo         (lo_reg),
    .hi         (hi_reg),
    .guess      (guess_reg),
    .flags      (flags),
    .lo_next    (lo_next),
    .hi_next    (hi_next),
    .guess_next (guess_next),
    .terminate  (terminate),
    .hit        (hit),
    .abort      (abort)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= SAR_IDLE;
      guess_reg  <= '0;
      lo_reg     <= '0;
      hi_reg     <= ALL_ONES;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      found_reg  <= 1'b0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        SAR_IDLE: begin
          if (bus.start) begin
            lo_reg    <= '0;
            hi_reg    <= ALL_ONES;
            guess_reg <= FIRST_GUESS;
            found_reg <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= SAR_PROBE;
          end
        end
        SAR_PROBE: begin
          // start is deliberately not looked at here: a running search is never restarted
          if (terminate) begin
            found_reg  <= hit;
            err_reg    <= abort;
            result_reg <= guess_reg;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= SAR_IDLE;
          end else begin
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
            guess_reg <= guess_next;
          end
        end
        default: state_reg <= SAR_IDLE;
      endcase
    end
  end

  assign bus.guess  = guess_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.found  = found_reg;
  assign bus.result = result_reg;
  assign bus.err    = err_reg;

endmodule

// File: tb/tb_sar_search.sv
// Scoreboarded random/directed bench for sar_search against a plain-arithmetic search model.
// Expectations follow SAR_SEARCH_CHECK_EN when the bench is built with it.
module tb_sar_search;

  typedef struct {
    bit found;
    int result;
    bit err;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sar_search_if #(.WIDTH(4)) bus ();
  sar_search_if #(.WIDTH(2)) bus2 ();

  sar_search #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  sar_search #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int total = 0;
  int bad = 0;
  int hidden_b = 0;
  int zero_probe = 0;
  int probe_cnt = 0;
  int cyc = 0;
  int start_cyc = 0;
  exp_t exp_q[$];
  int exp_g_q[$];
  int model_guesses[$];

  // Comparator for the WIDTH=4 instance, with an optional all-zero flag probe
  always_comb begin
    bus.cmp_gt = 1'b0;
    bus.cmp_lt = 1'b0;
    bus.cmp_eq = 1'b0;
    if (!(bus.busy && (probe_cnt + 1 == zero_probe))) begin
      bus.cmp_gt = int'(bus.guess) > hidden_b;
      bus.cmp_lt = int'(bus.guess) < hidden_b;
      bus.cmp_eq = int'(bus.guess) == hidden_b;
    end
  end

  // WIDTH=2 instance hunts for 4, which is out of range: comparator always says lt
  assign bus2.cmp_gt = int'(bus2.guess) > 4;
  assign bus2.cmp_lt = int'(bus2.guess) < 4;
  assign bus2.cmp_eq = int'(bus2.guess) == 4;

  always @(posedge clk) begin
    probe_cnt <= bus.busy ? probe_cnt + 1 : 0;
    cyc <= cyc + 1;
    if (!rst && bus.start && !bus.busy) start_cyc <= cyc;
  end

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference: textbook binary search over [0, 2^w-1], one probe per iteration
  function automatic exp_t model(input int b, input int zp, input int w);
    exp_t e;
    int lo = 0;
    int hi = (1 << w) - 1;
    int g;
    bit gt, lt, eq;
    e = '{found: 1'b0, result: 0, err: 1'b0, lat: 0};
    model_guesses.delete();
    for (int n = 1; n <= w + 2; n++) begin
      g = (lo + hi) / 2;
      model_guesses.push_back(g);
      eq = (g == b);
      gt = (g > b);
      lt = (g < b);
      if (n == zp) begin
        eq = 0; gt = 0; lt = 0;
      end
      e.result = g;
      e.lat = n + 1;
`ifdef SAR_SEARCH_CHECK_EN
      if (!eq && !gt && !lt) begin
        e.err = 1'b1;
        return e;
      end
`endif
      if (eq) begin
        e.found = 1'b1;
        return e;
      end
      if (gt) begin
        if (g == lo) return e;
        hi = g - 1;
      end else begin
        if (g == hi) return e;
        lo = g + 1;
      end
    end
    return e;
  endfunction

  // Monitor: every busy cycle is a probe, every done pulse ends a transaction
  always @(negedge clk) begin
    if (bus.busy) begin
      if (exp_g_q.size() == 0) fail_now("unexpected_probe");
      else check("guess", int'(bus.guess), exp_g_q.pop_front());
    end
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("found", int'(bus.found), int'(e.found));
        check("result", int'(bus.result), e.result);
        check("err", int'(bus.err), int'(e.err));
        check("latency", cyc - start_cyc, e.lat);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle
  task automatic do_search(input int b, input int zp, input bit poke);
    exp_t e;
    bit ok;
    hidden_b = b;
    zero_probe = zp;
    e = model(b, zp, 4);
    exp_q.push_back(e);
    foreach (model_guesses[k]) exp_g_q.push_back(model_guesses[k]);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      bus.start = poke && (i == 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (!ok) begin
      fail_now("done_timeout");
      exp_q.delete();
      exp_g_q.delete();
    end
    $display("search b=%0d zp=%0d poke=%0d: found=%0d result=%0d err=%0d",
             b, zp, poke, bus.found, bus.result, bus.err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_guess", int'(bus.guess), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_found", int'(bus.found), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_err", int'(bus.err), 0);
    rst = 1'b0;

    do_search(5, 0, 0);
    do_search(15, 0, 0);
    do_search(0, 0, 0);
    do_search(5, 2, 0);
    do_search(11, 0, 1);
    for (int t = 0; t < 30; t++)
      do_search(int'($urandom_range(0, 15)), 0, 1'($urandom_range(0, 1)));
    do_search(13, 0, 0);

    // Reset mid-search: B=9 probes 7 then 11, reset sampled at end of cycle 2
    hidden_b = 9;
    zero_probe = 0;
    exp_g_q.push_back(7);
    exp_g_q.push_back(11);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_guess", int'(bus.guess), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_found", int'(bus.found), 0);
    check("midrst_result", int'(bus.result), 0);
    check("midrst_err", int'(bus.err), 0);
    rst = 1'b0;
    $display("reset mid-search issued");
    do_search(9, 0, 0);

    // WIDTH=2 instance with a comparator that only ever says lt
    begin
      exp_t e2;
      int g2[$];
      bit ok2;
      e2 = model(4, 0, 2);
      g2 = model_guesses;
      bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      ok2 = 1'b0;
      for (int n = 1; n <= 8; n++) begin
        if (bus2.done) begin
          ok2 = 1'b1;
          check("w2_latency", n, e2.lat);
          check("w2_found", int'(bus2.found), int'(e2.found));
          check("w2_result", int'(bus2.result), e2.result);
          break;
        end
        if (bus2.busy) begin
          if (n - 1 < g2.size()) check("w2_guess", int'(bus2.guess), g2[n-1]);
          else fail_now("w2_extra_probe");
        end
        @(negedge clk);
      end
      if (!ok2) fail_now("w2_done_timeout");
      $display("search w2 forced-lt: found=%0d result=%0d", bus2.found, bus2.result);
    end

    repeat (3) @(negedge clk);
    check("sb_pending", exp_q.size(), 0);
    check("guess_pending", exp_g_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sar_search.md
# sar_search

Sequential binary-search controller that drives the A operand of an external magnitude comparator and consumes its `gt`/`lt`/`eq` flags. It locates the hidden B operand in at most WIDTH+1 probe cycles. It sits on the opposite side of the comparator interface from the combinational comparators in this codebase: they produce the flags, this block produces the operand and interprets the flags.

## Interface
Parameters:
- `WIDTH`, default 4: operand width; search range is 0 to 2^WIDTH-1.

Ports:
- `clk` input, 1 bit: clock. One clock domain.
- `rst` input, 1 bit: reset. Synchronous, active-high.
- `start` input, 1 bit: begin a search. Honoured only in IDLE.
- `guess` output, WIDTH bits: registered probe value, wired to comparator A.
- `cmp_gt` input, 1 bit: comparator flag, high when guess > B.
- `cmp_lt` input, 1 bit: comparator flag, high when guess < B.
- `cmp_eq` input, 1 bit: comparator flag, high when guess == B.
- `busy` output, 1 bit: high while in PROBE.
- `done` output, 1 bit: one-cycle completion pulse.
- `found` output, 1 bit: last search hit (eq seen). Held until the next start.
- `result` output, WIDTH bits: final guess of the last search. Held until the next start.
- `err` output, 1 bit: illegal flag combination aborted the last search. Held until the next start.

## Operation
States: IDLE and PROBE. Internal bounds `lo` and `hi`, each WIDTH bits.

- **Reset values:** state=IDLE, guess=0, lo=0, hi=all-ones, busy=0, done=0, found=0, result=0, err=0.
- **IDLE + start:**
  - lo←0, hi←2^WIDTH-1, guess←(2^WIDTH-1)>>1.
  - Clear found and err.
  - Go to PROBE.
- **PROBE:** each cycle, evaluate the flags against the current `guess`.
  - `eq`: found←1, result←guess, done pulse, go to IDLE.
  - `gt`:
    - If guess==lo: found←0, result←guess, done, go to IDLE (miss).
    - Otherwise hi←guess-1, guess←(lo+hi')>>1.
  - `lt`:
    - If guess==hi: miss, same as above.
    - Otherwise lo←guess+1, guess←(lo'+hi)>>1.
- **Arithmetic:**
  - The midpoint sum is computed WIDTH+1 bits wide, then shifted.
  - The guess==lo and guess==hi checks precede any ±1 update, so lo and hi never wrap.
- **Flag priority (macro off):** eq > gt > lt. If no flag is set, the block treats it as `lt`.
- **start while busy:** ignored; the search continues.
- **rst mid-search:** next cycle all outputs take their reset values and no done pulse is issued.
- **start during the done cycle:** the block is already in IDLE, so start is accepted.

## Timing
- The comparator is combinational. Flags must settle within the same cycle `guess` is presented.
- Cycle 0: start sampled in IDLE.
- Cycle 1: first guess is valid and busy=1.
- Probe k is evaluated in cycle k, for k=1..WIDTH+1.
- The terminating probe in cycle k gives done=1 and busy=0 in cycle k+1. found, result and err are valid in the same cycle.
- Worst-case latency, start to done: WIDTH+2 cycles.
- `guess` holds its last value while in IDLE.

## Configuration
- `SAR_SEARCH_CHECK_EN` defined: in PROBE, any flag vector that is not one-hot aborts the search.
  - Sets err←1, found←0, result←guess, done pulse, go to IDLE.
- `SAR_SEARCH_CHECK_EN` not defined:
  - err is tied to 0.
  - The priority rule from Operation applies.

## Structure
- Shared package `sar_pkg`:
  - State enum: `SAR_IDLE`, `SAR_PROBE`.
  - Flag index constants: `FLAG_GT`, `FLAG_LT`, `FLAG_EQ`, used for packing {gt,lt,eq}.
- One sub-module `sar_bounds` is natural. It is combinational and takes lo, hi, guess and the flags, and produces:
  - next lo, next hi, next guess;
  - terminate and hit.
- The top-level block holds the FSM and the output registers.

## Test plan
- WIDTH=4, B=5 → guesses 7, 3, 5; done in cycle 4; found=1, result=5.
- WIDTH=4, B=15 → guesses 7, 11, 13, 14, 15; done in cycle 6 (worst case); found=1, result=15.
- WIDTH=4, B=0 → guesses 7, 3, 1, 0; found=1, result=0; hi never underflows.
- WIDTH=2, comparator forced to `lt` → guesses 1, 2, 3; found=0, result=3; done in cycle 4.
- WIDTH=4, B=9, rst in cycle 2 → cycle 3 shows all reset values and no done pulse. A new start then finds result=9.
- `SAR_SEARCH_CHECK_EN` on, flags 3'b000 at probe 2 → err=1, found=0, done in cycle 3. Without the macro, the same stimulus gives err=0 and the search continues as `lt`.
